// File: rtl/skolem_udiv_sle_checker.sv
// Exhaustive certifier for the bvsle(bvudiv(A,B), sext(y)) Skolem stage.
// Each universal assignment goes through DRIVE -> W-cycle restoring divide -> CHECK.
module skolem_udiv_sle_checker #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic [2*W-1:0] x_o,
  input  logic           sk_i,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [2*W:0]   fail_cnt,
  output logic [2*W:0]   unreal_cnt,
  output logic [2*W-1:0] first_fail,
  output logic           first_fail_vld
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [2:0] {IDLE, DRIVE, DIV, CHECK, FIN} state_t;

  state_t         state_q, state_d;
  logic [2*W-1:0] x_q, x_d;
  logic [2*W:0]   fail_q, fail_d, unreal_q, unreal_d;
  logic [2*W-1:0] ff_q, ff_d;
  logic           ffv_q, ffv_d, pass_q, pass_d, sk_q, sk_d;
  logic [W-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  // Restoring step: shift next dividend bit into the partial remainder, subtract if it fits.
  logic [W:0]     shifted;
  logic           fits;
  logic [W-1:0]   diff;
  logic [W-1:0]   q;
  logic           f0, f1, fy;

  assign shifted = {rem_q, quo_q[W-1]};
  assign fits    = shifted >= {1'b0, dvs_q};
  assign diff    = shifted[W-1:0] - dvs_q;
  assign q       = (dvs_q == '0) ? '1 : quo_q;
  assign f0      = (q == '0) | q[W-1];
  assign f1      = q[W-1];
  assign fy      = sk_q ? f1 : f0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      fail_q   <= '0;
      unreal_q <= '0;
      ff_q     <= '0;
      ffv_q    <= 1'b0;
      pass_q   <= 1'b0;
      sk_q     <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      fail_q   <= fail_d;
      unreal_q <= unreal_d;
      ff_q     <= ff_d;
      ffv_q    <= ffv_d;
      pass_q   <= pass_d;
      sk_q     <= sk_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    fail_d   = fail_q;
    unreal_d = unreal_q;
    ff_d     = ff_q;
    ffv_d    = ffv_q;
    pass_d   = pass_q;
    sk_d     = sk_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = DRIVE;
          x_d      = '0;
          fail_d   = '0;
          unreal_d = '0;
          ff_d     = '0;
          ffv_d    = 1'b0;
          pass_d   = 1'b0;
        end
      end
      DRIVE: begin
        sk_d    = sk_i;
        rem_d   = '0;
        quo_d   = x_q[W-1:0];
        dvs_d   = x_q[2*W-1:W];
        cnt_d   = '0;
        state_d = DIV;
      end
      DIV: begin
        rem_d = fits ? diff : shifted[W-1:0];
        quo_d = {quo_q[W-2:0], fits};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) state_d = CHECK;
      end
      CHECK: begin
        if (!f0) begin
          unreal_d = unreal_q + (2*W+1)'(1);
        end else if (!fy) begin
          fail_d = fail_q + (2*W+1)'(1);
          if (!ffv_q) begin
            ff_d  = x_q;
            ffv_d = 1'b1;
          end
        end
        if (x_q == '1) begin
          state_d = FIN;
          // Latched here so pass is already valid in the done cycle.
          pass_d  = (fail_d == '0);
        end else begin
          x_d     = x_q + (2*W)'(1);
          state_d = DRIVE;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign x_o            = x_q;
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == FIN);
  assign pass           = pass_q;
  assign fail_cnt       = fail_q;
  assign unreal_cnt     = unreal_q;
  assign first_fail     = ff_q;
  assign first_fail_vld = ffv_q;

endmodule

// File: tb/tb_skolem_udiv_sle_checker.sv
// Sweeps the checker against several Skolem-stage behaviours, including a random
// truth table, and compares timing and results with an arithmetic reference.
module tb_skolem_udiv_sle_checker;

  logic        clk = 1'b0;
  logic        rst, start, sk_i;
  logic [7:0]  x_o;
  logic        busy, done, pass, first_fail_vld;
  logic [8:0]  fail_cnt, unreal_cnt;
  logic [7:0]  first_fail;

  int          mode;
  logic [255:0] rnd_tab;
  int          n_chk, n_pass;
  int          exp_fail, exp_unreal, exp_ff;
  bit          exp_ffv;

  always #5 clk = ~clk;

  skolem_udiv_sle_checker #(.W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .x_o(x_o), .sk_i(sk_i),
    .busy(busy), .done(done), .pass(pass), .fail_cnt(fail_cnt),
    .unreal_cnt(unreal_cnt), .first_fail(first_fail),
    .first_fail_vld(first_fail_vld)
  );

  // Behaviour of the Skolem stage under test.
  assign sk_i = (mode == 1) | (mode == 2 && x_o == 8'h93) |
                (mode == 3 && x_o[7:4] == 4'd0) | (mode == 4 && rnd_tab[x_o]);

  function automatic bit sk_model(input int m, input int x);
    case (m)
      1:       return 1'b1;
      2:       return x == 'h93;
      3:       return (x / 16) == 0;
      4:       return rnd_tab[x];
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model(input int m);
    exp_fail = 0; exp_unreal = 0; exp_ff = 0; exp_ffv = 0;
    for (int x = 0; x < 256; x++) begin
      int a, b, qq;
      bit r, y, ok;
      a  = x % 16;
      b  = x / 16;
      qq = (b == 0) ? 15 : a / b;
      r  = (qq == 0) || (qq >= 8);
      y  = sk_model(m, x);
      ok = y ? (qq >= 8) : r;
      if (!r) exp_unreal++;
      else if (!ok) begin
        exp_fail++;
        if (!exp_ffv) begin exp_ff = x; exp_ffv = 1; end
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".x"}, x_o, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".pass"}, pass, 0);
    chk({tag, ".fail"}, fail_cnt, 0);
    chk({tag, ".unreal"}, unreal_cnt, 0);
    chk({tag, ".ff"}, first_fail, 0);
    chk({tag, ".ffv"}, first_fail_vld, 0);
  endtask

  task automatic sweep(input string nm, input int m, input bit extras, input int abort_at);
    int done_cyc, done_n, busy_err, x_err;
    done_cyc = -1; done_n = 0; busy_err = 0; x_err = 0;
    model(m);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 1545; k++) begin
      if (abort_at > 0 && k == abort_at + 1) begin
        rst = 1'b0;
        chk_reset_vals({nm, ".abort"});
        chk({nm, ".abort_done"}, done_n, 0);
        return;
      end
      if (busy !== (k <= 1537)) busy_err++;
      if (k <= 1536 && x_o !== 8'((k - 1) / 6)) x_err++;
      if (done === 1'b1) begin
        done_n++;
        if (done_cyc < 0) done_cyc = k;
        chk({nm, ".pass@done"}, pass, (exp_fail == 0));
      end
      start = extras && (k == 3 || k == 900 || k == 1537);
      if (abort_at > 0 && k == abort_at) rst = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    chk({nm, ".done_cyc"}, done_cyc, 1537);
    chk({nm, ".done_n"}, done_n, 1);
    chk({nm, ".busy_err"}, busy_err, 0);
    chk({nm, ".x_err"}, x_err, 0);
    chk({nm, ".pass"}, pass, (exp_fail == 0));
    chk({nm, ".fail"}, fail_cnt, exp_fail);
    chk({nm, ".unreal"}, unreal_cnt, exp_unreal);
    chk({nm, ".ffv"}, first_fail_vld, exp_ffv);
    if (exp_ffv) chk({nm, ".ff"}, first_fail, exp_ff);
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b1; start = 1'b0; mode = 0;
    rnd_tab = {$urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom, $urandom};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("reset");

    sweep("sk0", 0, 1'b0, 0);
    chk("sk0.unreal_abs", unreal_cnt, 112);
    sweep("sk1", 1, 1'b0, 0);
    chk("sk1.fail_abs", fail_cnt, 120);
    chk("sk1.ff_abs", first_fail, 8'h10);
    sweep("sk93", 2, 1'b0, 0);
    chk("sk93.ff_abs", first_fail, 8'h93);
    sweep("abort", 0, 1'b0, 500);
    repeat (2) @(negedge clk);
    chk("abort.idle_busy", busy, 0);
    sweep("rerun", 0, 1'b0, 0);
    sweep("extras", 0, 1'b1, 0);
    chk("extras.idle_after", busy, 0);
    sweep("div0", 3, 1'b0, 0);
    sweep("rnd1", 4, 1'b0, 0);
    rnd_tab = {$urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom, $urandom};
    sweep("rnd2", 4, 1'b0, 0);
    repeat (5) @(negedge clk);
    chk("hold.fail", fail_cnt, exp_fail);
    chk("hold.busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
